// File: rtl/exec_unit.sv
// exec_unit - execute/control stage downstream of the fetch/sequencer core.
//
// Owns a 4x8-bit register file (r0..r3), the {N,C,Z} flags and an 8-bit
// output port. While the core is in its execute state it decodes the
// instruction register. It performs single-step ops at CLK_0, two-step
// ALU/shift ops at CLK_0..CLK_1 and a shift-add multiply at CLK_0..CLK_9.
// It returns the per-instruction handshake that the core samples.
//
// Ports
//   clk            system clock, rising edge
//   reset          asynchronous, active-high
//   ir[31:0]       instruction: [31:24] opcode, [23:20] cond, [19:18] rd,
//                  [17:16] rs, [7:0] imm/address
//   clks[15:0]     one-hot step counter from the core (bit k = CLK_k)
//   state[1:0]     core state; all activity gated by state == STATE_IE
//   in_data[7:0]   external byte for IN
//   inst_condition cond field satisfied (combinational)
//   end_inst       final step of the current instruction (combinational)
//   jmp_inst       taken jump (combinational)
//   hlt_inst       halt request (combinational)
//   jmp_address    jump target, always ir[7:0]
//   out_data[7:0]  output port register
//   out_valid      one-cycle strobe following an out_data write
//   flags[2:0]     {N,C,Z}
//   illegal        (EXEC_ILLEGAL_TRAP_EN only) sticky undefined-opcode flag
//
// Optional build macro: EXEC_ILLEGAL_TRAP_EN. When defined, undefined opcodes
// with a true cond request a halt at CLK_0 and set the sticky illegal output.
// When undefined, undefined opcodes behave as NOP.
//
// Halt FSM
//   state   | meaning
//   EX_RUN  | normal execution
//   EX_HALT | HLT (or trapped opcode) seen; no writes until reset

module exec_unit #(
  parameter logic [1:0] STATE_IE = 2'd1,
  parameter logic [7:0] REG_INIT = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic [15:0] clks,
  input  logic [1:0]  state,
  input  logic [7:0]  in_data,
  output logic        inst_condition,
  output logic        end_inst,
  output logic        jmp_inst,
  output logic        hlt_inst,
  output logic [7:0]  jmp_address,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic [2:0]  flags
`ifdef EXEC_ILLEGAL_TRAP_EN
  ,
  output logic        illegal
`endif
);

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LDI = 8'h01;
  localparam logic [7:0] OP_MOV = 8'h02;
  localparam logic [7:0] OP_ADD = 8'h03;
  localparam logic [7:0] OP_SUB = 8'h04;
  localparam logic [7:0] OP_AND = 8'h05;
  localparam logic [7:0] OP_OR  = 8'h06;
  localparam logic [7:0] OP_XOR = 8'h07;
  localparam logic [7:0] OP_SHL = 8'h08;
  localparam logic [7:0] OP_SHR = 8'h09;
  localparam logic [7:0] OP_IN  = 8'h0A;
  localparam logic [7:0] OP_OUT = 8'h0B;
  localparam logic [7:0] OP_JMP = 8'h0C;
  localparam logic [7:0] OP_MUL = 8'h0D;
  localparam logic [7:0] OP_HLT = 8'h0F;

  typedef enum logic {EX_RUN, EX_HALT} ex_state_t;

  ex_state_t ex_state, ex_next;

  logic [7:0] opcode;
  logic [3:0] cond;
  logic [1:0] rd_sel, rs_sel;
  logic [7:0] imm;
  logic       unused_ir;

  assign opcode    = ir[31:24];
  assign cond      = ir[23:20];
  assign rd_sel    = ir[19:18];
  assign rs_sel    = ir[17:16];
  assign imm       = ir[7:0];
  assign unused_ir = ^ir[15:8];

  assign jmp_address = imm;

  logic [7:0]  regs [4];
  logic [15:0] mul_a;   // multiplicand, shifted left each MUL step; low byte doubles as ALU operand A
  logic [7:0]  mul_b;   // multiplier, shifted right each MUL step; doubles as ALU operand B
  logic [15:0] mul_p;

  logic flag_z, flag_c, flag_n;
  assign flag_z = flags[0];
  assign flag_c = flags[1];
  assign flag_n = flags[2];

  // Exact one-hot matches so that malformed step vectors cause no write.
  logic step0, step1, step9, mul_step;
  assign step0    = (clks == 16'h0001);
  assign step1    = (clks == 16'h0002);
  assign step9    = (clks == 16'h0200);
  assign mul_step = ((clks & (clks - 16'd1)) == 16'h0000) && (clks[8:1] != 8'h00);

  logic cond_ok;
  always_comb begin
    cond_ok = 1'b1;
    case (cond)
      4'h1:    cond_ok = flag_z;
      4'h2:    cond_ok = !flag_z;
      4'h3:    cond_ok = flag_c;
      4'h4:    cond_ok = !flag_c;
      4'h5:    cond_ok = flag_n;
      4'h6:    cond_ok = !flag_n;
      default: cond_ok = 1'b1;
    endcase
  end

  // ALU for the two-step ops, working on the operands latched at CLK_0.
  logic [7:0] alu_a, alu_b, alu_res;
  logic       alu_c;
  logic [8:0] alu_sum;

  assign alu_a   = mul_a[7:0];
  assign alu_b   = mul_b;
  assign alu_sum = {1'b0, alu_a} + {1'b0, alu_b};

  always_comb begin
    alu_res = 8'h00;
    alu_c   = 1'b0;
    case (opcode)
      OP_ADD: begin alu_res = alu_sum[7:0];    alu_c = alu_sum[8];    end
      OP_SUB: begin alu_res = alu_a - alu_b;   alu_c = alu_a < alu_b; end
      OP_AND: alu_res = alu_a & alu_b;
      OP_OR:  alu_res = alu_a | alu_b;
      OP_XOR: alu_res = alu_a ^ alu_b;
      OP_SHL: begin alu_res = {alu_a[6:0], 1'b0}; alu_c = alu_a[7]; end
      OP_SHR: begin alu_res = {1'b0, alu_a[7:1]}; alu_c = alu_a[0]; end
      default: begin alu_res = 8'h00; alu_c = 1'b0; end
    endcase
  end

  logic       is_ie, running;
  logic       rf_we, flag_we, out_we;
  logic [7:0] rf_wdata;
  logic [2:0] flag_next;
  logic       op_load, mul_load, mul_shift;
  logic       illegal_set;

  always_comb begin
    ex_next        = ex_state;
    inst_condition = 1'b0;
    end_inst       = 1'b0;
    jmp_inst       = 1'b0;
    hlt_inst       = 1'b0;
    rf_we          = 1'b0;
    rf_wdata       = 8'h00;
    flag_we        = 1'b0;
    flag_next      = flags;
    out_we         = 1'b0;
    op_load        = 1'b0;
    mul_load       = 1'b0;
    mul_shift      = 1'b0;
    illegal_set    = 1'b0;

    is_ie   = (state == STATE_IE);
    running = is_ie && (ex_state == EX_RUN);

    if (is_ie && ex_state == EX_HALT) begin
      // Keep the halt request up while idling so the core stays parked.
      hlt_inst = 1'b1;
    end else if (running) begin
      inst_condition = cond_ok;
      if (!cond_ok) begin
        end_inst = step0;
      end else begin
        case (opcode)
          OP_NOP: end_inst = step0;
          OP_LDI: begin end_inst = step0; rf_we = step0; rf_wdata = imm;            end
          OP_MOV: begin end_inst = step0; rf_we = step0; rf_wdata = regs[rs_sel];   end
          OP_IN:  begin end_inst = step0; rf_we = step0; rf_wdata = in_data;        end
          OP_OUT: begin end_inst = step0; out_we = step0;                           end
          OP_JMP: begin end_inst = step0; jmp_inst = step0;                         end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
            op_load  = step0;
            end_inst = step1;
            if (step1) begin
              rf_we     = 1'b1;
              rf_wdata  = alu_res;
              flag_we   = 1'b1;
              flag_next = {alu_res[7], alu_c, alu_res == 8'h00};
            end
          end
          OP_MUL: begin
            mul_load  = step0;
            mul_shift = mul_step;
            end_inst  = step9;
            if (step9) begin
              rf_we     = 1'b1;
              rf_wdata  = mul_p[7:0];
              flag_we   = 1'b1;
              flag_next = {mul_p[7], mul_p[15:8] != 8'h00, mul_p[7:0] == 8'h00};
            end
          end
          OP_HLT: begin
            hlt_inst = step0;
            if (step0) ex_next = EX_HALT;
          end
          default: begin
`ifdef EXEC_ILLEGAL_TRAP_EN
            hlt_inst = step0;
            if (step0) begin
              ex_next     = EX_HALT;
              illegal_set = 1'b1;
            end
`else
            end_inst = step0;
`endif
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ex_state <= EX_RUN;
    else       ex_state <= ex_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) regs[i] <= REG_INIT;
      flags     <= 3'b000;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      mul_a     <= 16'h0000;
      mul_b     <= 8'h00;
      mul_p     <= 16'h0000;
    end else begin
      out_valid <= out_we;
      if (rf_we)   regs[rd_sel] <= rf_wdata;
      if (flag_we) flags <= flag_next;
      if (out_we)  out_data <= regs[rs_sel];
      if (op_load || mul_load) begin
        mul_a <= {8'h00, regs[rd_sel]};
        mul_b <= regs[rs_sel];
      end
      if (mul_load) mul_p <= 16'h0000;
      if (mul_shift) begin
        if (mul_b[0]) mul_p <= mul_p + mul_a;
        mul_a <= {mul_a[14:0], 1'b0};
        mul_b <= {1'b0, mul_b[7:1]};
      end
    end
  end

`ifdef EXEC_ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            illegal <= 1'b0;
    else if (illegal_set) illegal <= 1'b1;
  end
`else
  logic unused_trap;
  assign unused_trap = illegal_set;
`endif

endmodule

// File: tb/tb_exec_unit.sv
module tb_exec_unit;
  localparam logic [1:0] IE = 2'd1;
  localparam logic [7:0] RI = 8'h00;

  logic        clk, reset;
  logic [31:0] ir;
  logic [15:0] clks;
  logic [1:0]  state;
  logic [7:0]  in_data;
  logic        inst_condition, end_inst, jmp_inst, hlt_inst;
  logic [7:0]  jmp_address, out_data;
  logic        out_valid;
  logic [2:0]  flags;
`ifdef EXEC_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  exec_unit #(.STATE_IE(IE), .REG_INIT(RI)) dut (
    .clk(clk), .reset(reset), .ir(ir), .clks(clks), .state(state),
    .in_data(in_data), .inst_condition(inst_condition), .end_inst(end_inst),
    .jmp_inst(jmp_inst), .hlt_inst(hlt_inst), .jmp_address(jmp_address),
    .out_data(out_data), .out_valid(out_valid), .flags(flags)
`ifdef EXEC_ILLEGAL_TRAP_EN
    , .illegal(illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: architectural state only.
  logic [7:0] m_r [4];
  bit         m_z, m_c, m_n;
  logic [7:0] m_out;

  function automatic bit m_cond(input logic [3:0] c);
    case (c)
      4'h1: return m_z;
      4'h2: return !m_z;
      4'h3: return m_c;
      4'h4: return !m_c;
      4'h5: return m_n;
      4'h6: return !m_n;
      default: return 1'b1;
    endcase
  endfunction

  task automatic m_set(input logic [1:0] rd, input int res, input bit cy);
    m_r[rd] = res[7:0];
    m_z = (res[7:0] == 8'h00);
    m_n = res[7];
    m_c = cy;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_r[i] = RI;
    m_z = 0; m_c = 0; m_n = 0; m_out = 8'h00;
  endtask

  task automatic model_exec(input logic [7:0] op, input logic [3:0] cnd,
                            input logic [1:0] rd, input logic [1:0] rs,
                            input logic [7:0] imm, input logic [7:0] din,
                            output int last, output bit c_ok, output bit jmp,
                            output bit hlt, output bit outv);
    int a, b;
    c_ok = m_cond(cnd);
    last = 0; jmp = 0; hlt = 0; outv = 0;
    if (!c_ok) return;
    a = int'(m_r[rd]);
    b = int'(m_r[rs]);
    case (op)
      8'h00: ;
      8'h01: m_r[rd] = imm;
      8'h02: m_r[rd] = b[7:0];
      8'h0A: m_r[rd] = din;
      8'h0B: begin m_out = b[7:0]; outv = 1; end
      8'h0C: jmp = 1;
      8'h03: begin m_set(rd, a + b, (a + b) > 255); last = 1; end
      8'h04: begin m_set(rd, (a - b) & 255, a < b); last = 1; end
      8'h05: begin m_set(rd, a & b, 0); last = 1; end
      8'h06: begin m_set(rd, a | b, 0); last = 1; end
      8'h07: begin m_set(rd, a ^ b, 0); last = 1; end
      8'h08: begin m_set(rd, (a * 2) % 256, a >= 128); last = 1; end
      8'h09: begin m_set(rd, a / 2, (a % 2) == 1); last = 1; end
      8'h0D: begin m_set(rd, (a * b) % 256, (a * b) > 255); last = 9; end
      8'h0F: begin hlt = 1; last = -1; end
      default: begin
`ifdef EXEC_ILLEGAL_TRAP_EN
        hlt = 1; last = -1;
`endif
      end
    endcase
  endtask

  // Drives one instruction through its steps, then two non-IE cycles.
  task automatic do_inst(input logic [7:0] op, input logic [3:0] cnd,
                         input logic [1:0] rd, input logic [1:0] rs,
                         input logic [7:0] imm, input logic [7:0] din,
                         input int last, input bit e_cond, input bit e_jmp,
                         input bit e_hlt, input bit e_outv,
                         input logic [7:0] e_out, input logic [2:0] e_flags,
                         input string tag);
    int nsteps;
    nsteps = (last < 0) ? 1 : last + 1;
    for (int k = 0; k < nsteps; k++) begin
      @(negedge clk);
      ir = {op, cnd, rd, rs, 8'h00, imm};
      in_data = din;
      state = IE;
      clks = 16'(1) << k;
      #1;
      chk($sformatf("%s end_inst s%0d", tag, k), end_inst, (k == last));
      chk($sformatf("%s inst_condition s%0d", tag, k), inst_condition, e_cond);
      chk($sformatf("%s jmp_inst s%0d", tag, k), jmp_inst, (e_jmp && k == 0));
      chk($sformatf("%s hlt_inst s%0d", tag, k), hlt_inst, (e_hlt && k == 0));
      chk($sformatf("%s jmp_address s%0d", tag, k), jmp_address, imm);
    end
    // Non-IE cycle with a live-looking step: nothing may happen.
    @(negedge clk);
    state = 2'd0;
    clks = 16'h0001;
    #1;
    chk({tag, " handshake idle"}, {inst_condition, end_inst, jmp_inst, hlt_inst}, 4'b0000);
    chk({tag, " out_valid"}, out_valid, e_outv);
    chk({tag, " out_data"}, out_data, e_out);
    chk({tag, " flags"}, flags, e_flags);
    @(negedge clk);
    #1;
    chk({tag, " out_valid drop"}, out_valid, 1'b0);
  endtask

  task automatic run(input logic [7:0] op, input logic [3:0] cnd,
                     input logic [1:0] rd, input logic [1:0] rs,
                     input logic [7:0] imm, input logic [7:0] din, input string tag);
    int last; bit c_ok, jmp, hlt, outv;
    model_exec(op, cnd, rd, rs, imm, din, last, c_ok, jmp, hlt, outv);
    do_inst(op, cnd, rd, rs, imm, din, last, c_ok, jmp, hlt, outv, m_out,
            {m_n, m_c, m_z}, tag);
  endtask

  typedef struct {
    logic [7:0] op;
    logic [3:0] cnd;
    logic [1:0] rd, rs;
    logic [7:0] imm, din;
    int         last;
    bit         e_cond, e_jmp, e_outv;
    logic [7:0] e_out;
    logic [2:0] e_flags;
  } vec_t;

  vec_t tbl [27];

  initial begin
    int last; bit c_ok, jmp, hlt, outv;
    logic [7:0] op;
    logic [2:0] hold_flags;
    logic [7:0] hold_out;

    //        op    cnd  rd    rs    imm    din  last cond jmp outv out    {N,C,Z}
    tbl[0]  = '{8'h01, 4'h0, 2'd0, 2'd0, 8'h7F, 8'h00, 0, 1, 0, 0, 8'h00, 3'b000};
    tbl[1]  = '{8'h01, 4'h0, 2'd1, 2'd0, 8'h01, 8'h00, 0, 1, 0, 0, 8'h00, 3'b000};
    tbl[2]  = '{8'h03, 4'h0, 2'd0, 2'd1, 8'h00, 8'h00, 1, 1, 0, 0, 8'h00, 3'b100};
    tbl[3]  = '{8'h0B, 4'h0, 2'd0, 2'd0, 8'h00, 8'h00, 0, 1, 0, 1, 8'h80, 3'b100};
    tbl[4]  = '{8'h01, 4'h0, 2'd2, 2'd0, 8'h03, 8'h00, 0, 1, 0, 0, 8'h80, 3'b100};
    tbl[5]  = '{8'h04, 4'h0, 2'd2, 2'd2, 8'h00, 8'h00, 1, 1, 0, 0, 8'h80, 3'b001};
    tbl[6]  = '{8'h0C, 4'h1, 2'd0, 2'd0, 8'h20, 8'h00, 0, 1, 1, 0, 8'h80, 3'b001};
    tbl[7]  = '{8'h0C, 4'h2, 2'd0, 2'd0, 8'h44, 8'h00, 0, 0, 0, 0, 8'h80, 3'b001};
    tbl[8]  = '{8'h01, 4'h0, 2'd3, 2'd0, 8'h0D, 8'h00, 0, 1, 0, 0, 8'h80, 3'b001};
    tbl[9]  = '{8'h01, 4'h0, 2'd1, 2'd0, 8'h0B, 8'h00, 0, 1, 0, 0, 8'h80, 3'b001};
    tbl[10] = '{8'h0D, 4'h0, 2'd3, 2'd1, 8'h00, 8'h00, 9, 1, 0, 0, 8'h80, 3'b100};
    tbl[11] = '{8'h0B, 4'h0, 2'd0, 2'd3, 8'h00, 8'h00, 0, 1, 0, 1, 8'h8F, 3'b100};
    tbl[12] = '{8'h01, 4'h0, 2'd0, 2'd0, 8'h20, 8'h00, 0, 1, 0, 0, 8'h8F, 3'b100};
    tbl[13] = '{8'h01, 4'h0, 2'd1, 2'd0, 8'h10, 8'h00, 0, 1, 0, 0, 8'h8F, 3'b100};
    tbl[14] = '{8'h0D, 4'h0, 2'd0, 2'd1, 8'h00, 8'h00, 9, 1, 0, 0, 8'h8F, 3'b011};
    tbl[15] = '{8'h0B, 4'h0, 2'd0, 2'd0, 8'h00, 8'h00, 0, 1, 0, 1, 8'h00, 3'b011};
    tbl[16] = '{8'h0A, 4'h0, 2'd0, 2'd0, 8'h00, 8'hA5, 0, 1, 0, 0, 8'h00, 3'b011};
    tbl[17] = '{8'h0B, 4'h0, 2'd0, 2'd0, 8'h00, 8'h00, 0, 1, 0, 1, 8'hA5, 3'b011};
    tbl[18] = '{8'h03, 4'h0, 2'd1, 2'd1, 8'h00, 8'h00, 1, 1, 0, 0, 8'hA5, 3'b000};
    tbl[19] = '{8'h0B, 4'h0, 2'd0, 2'd1, 8'h00, 8'h00, 0, 1, 0, 1, 8'h20, 3'b000};
    tbl[20] = '{8'h08, 4'h0, 2'd3, 2'd0, 8'h00, 8'h00, 1, 1, 0, 0, 8'h20, 3'b010};
    tbl[21] = '{8'h09, 4'h0, 2'd3, 2'd0, 8'h00, 8'h00, 1, 1, 0, 0, 8'h20, 3'b000};
    tbl[22] = '{8'h0B, 4'h0, 2'd0, 2'd3, 8'h00, 8'h00, 0, 1, 0, 1, 8'h0F, 3'b000};
    tbl[23] = '{8'h01, 4'h3, 2'd2, 2'd0, 8'hFF, 8'h00, 0, 0, 0, 0, 8'h0F, 3'b000};
    tbl[24] = '{8'h0B, 4'h0, 2'd0, 2'd2, 8'h00, 8'h00, 0, 1, 0, 1, 8'h00, 3'b000};
    tbl[25] = '{8'h02, 4'h0, 2'd0, 2'd3, 8'h00, 8'h00, 0, 1, 0, 0, 8'h00, 3'b000};
    tbl[26] = '{8'h0B, 4'h0, 2'd0, 2'd0, 8'h00, 8'h00, 0, 1, 0, 1, 8'h0F, 3'b000};

    reset = 1'b1;
    ir = 32'h0C0000AB;
    clks = 16'h0000;
    state = 2'd0;
    in_data = 8'h00;
    m_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("reset flags", flags, 3'b000);
    chk("reset out_data", out_data, 8'h00);
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset handshake", {inst_condition, end_inst, jmp_inst, hlt_inst}, 4'b0000);
    chk("reset jmp_address", jmp_address, 8'hAB);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 27; i++) begin
      model_exec(tbl[i].op, tbl[i].cnd, tbl[i].rd, tbl[i].rs, tbl[i].imm, tbl[i].din,
                 last, c_ok, jmp, hlt, outv);
      do_inst(tbl[i].op, tbl[i].cnd, tbl[i].rd, tbl[i].rs, tbl[i].imm, tbl[i].din,
              tbl[i].last, tbl[i].e_cond, tbl[i].e_jmp, 1'b0, tbl[i].e_outv,
              tbl[i].e_out, tbl[i].e_flags, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 300; i++) begin
      int sel;
      sel = $urandom_range(0, 15);
      if (sel <= 13)      op = 8'(sel);
`ifdef EXEC_ILLEGAL_TRAP_EN
      else                op = 8'h00;
`else
      else if (sel == 14) op = 8'h0E;
      else                op = 8'h10 + 8'($urandom_range(0, 200));
`endif
      run(op, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
          2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
          $sformatf("rnd%0d op%0h", i, op));
    end

    // Reset in the middle of a MUL: nothing from it may survive.
    run(8'h01, 4'h0, 2'd0, 2'd0, 8'h05, 8'h00, "pre-mul ldi r0");
    run(8'h01, 4'h0, 2'd1, 2'd0, 8'h07, 8'h00, "pre-mul ldi r1");
    run(8'h01, 4'h0, 2'd2, 2'd0, 8'hC3, 8'h00, "pre-mul ldi r2");
    run(8'h01, 4'h0, 2'd3, 2'd0, 8'h3C, 8'h00, "pre-mul ldi r3");
    run(8'h0B, 4'h0, 2'd0, 2'd2, 8'h00, 8'h00, "pre-mul out");
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      ir = {8'h0D, 4'h0, 2'd0, 2'd1, 8'h00, 8'h00};
      state = IE;
      clks = 16'(1) << k;
    end
    #1;
    reset = 1'b1;
    m_reset();
    @(negedge clk);
    state = 2'd0;
    clks = 16'h0000;
    #1;
    chk("midmul flags", flags, 3'b000);
    chk("midmul out_data", out_data, 8'h00);
    chk("midmul out_valid", out_valid, 1'b0);
    reset = 1'b0;
    for (int r = 0; r < 4; r++)
      run(8'h0B, 4'h0, 2'd0, 2'(r), 8'h00, 8'h00, $sformatf("midmul r%0d", r));

    // HLT: afterwards no register, flag or port activity.
    run(8'h01, 4'h0, 2'd2, 2'd0, 8'hF0, 8'h00, "prehlt ldi");
    run(8'h03, 4'h0, 2'd2, 2'd2, 8'h00, 8'h00, "prehlt add");
    run(8'h0B, 4'h0, 2'd0, 2'd2, 8'h00, 8'h00, "prehlt out");
    run(8'h0F, 4'h0, 2'd0, 2'd0, 8'h00, 8'h00, "hlt");
    hold_flags = {m_n, m_c, m_z};
    hold_out = m_out;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] hop;
      @(negedge clk);
      case (i % 4)
        0: hop = 8'h01;
        1: hop = 8'h0B;
        2: hop = 8'h03;
        default: hop = 8'h0D;
      endcase
      ir = {hop, 4'h0, 2'd2, 2'd2, 8'h00, 8'h11};
      state = IE;
      clks = 16'(1) << (i % 10);
      #1;
      chk($sformatf("halted flags %0d", i), flags, hold_flags);
      chk($sformatf("halted out_data %0d", i), out_data, hold_out);
      chk($sformatf("halted out_valid %0d", i), out_valid, 1'b0);
      chk($sformatf("halted end/jmp %0d", i), {end_inst, jmp_inst}, 2'b00);
    end
    @(negedge clk);
    state = 2'd0;
    reset = 1'b1;
    m_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < 4; r++)
      run(8'h0B, 4'h0, 2'd0, 2'(r), 8'h00, 8'h00, $sformatf("posthlt r%0d", r));
    run(8'h01, 4'h0, 2'd1, 2'd0, 8'h9C, 8'h00, "posthlt ldi");
    run(8'h0B, 4'h0, 2'd0, 2'd1, 8'h00, 8'h00, "posthlt out");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
